// File: rtl/gain_proc.sv
// Offset-binary sample processor: signed fixed-point gain, saturation, DAC re-offset, clip counting.
// Optional 4-tap moving average on the converted sample when MOVAVG4_EN is defined.
module gain_proc #(
  parameter int              DW         = 10,
  parameter int              GW         = 8,
  parameter int              FRAC       = 4,
  parameter logic [GW-1:0]   GAIN_RST   = 8'h40,
  parameter logic [DW-1:0]   ADC_OFFSET = 10'h181,
  parameter logic [DW-1:0]   DAC_OFFSET = 10'h200
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [DW-1:0] data_in,
  input  logic          gain_ld,
  input  logic [GW-1:0] gain_in,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          clip,
  output logic [15:0]   clip_count
);

  localparam int PW = DW + GW;
  localparam logic signed [PW-1:0] YMAX = {{(GW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN = {{(GW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [GW-1:0] pendGain_q, pendGain_d;
  logic [GW-1:0] actGain_q, actGain_d;
  logic [DW-1:0] s1X_q, s1X_d;
  logic          s1Valid_q;

  logic [DW-1:0] mulX;
  logic [GW-1:0] mulG;
  logic          mulValid;

  logic signed [PW-1:0] mulXExt, mulGExt;
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 prodValid_q;

  logic signed [PW-1:0] shifted;
  logic [DW-1:0]        s3Y_q, s3Y_d;
  logic                 s3Clip_q, s3Clip_d;
  logic                 s3Valid_q;

  logic [DW-1:0] dataOut_q, dataOut_d;
  logic          clip_q, clip_d;
  logic          valid_q;
  logic [15:0]   clipCnt_q, clipCnt_d;

  // actGain_q doubles as the gain tag of the sample sitting in S1.
  always_comb begin
    pendGain_d = pendGain_q;
    actGain_d  = actGain_q;
    s1X_d      = s1X_q;
    if (gain_ld)
      pendGain_d = gain_in;
    if (sample_en) begin
      actGain_d = gain_ld ? gain_in : pendGain_q;
      s1X_d     = data_in - ADC_OFFSET;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pendGain_q <= GAIN_RST;
      actGain_q  <= GAIN_RST;
      s1X_q      <= '0;
      s1Valid_q  <= 1'b0;
    end else begin
      pendGain_q <= pendGain_d;
      actGain_q  <= actGain_d;
      s1X_q      <= s1X_d;
      s1Valid_q  <= sample_en;
    end
  end

`ifdef MOVAVG4_EN
  // Newest history entry is s1X_q itself; hist_q holds the three before it.
  logic [DW-1:0] hist_q [3];
  logic [DW-1:0] hist_d [3];
  logic [DW+1:0] avgSum;
  logic [DW-1:0] avgX_q, avgX_d;
  logic [GW-1:0] avgGain_q;
  logic          avgValid_q;

  always_comb begin
    avgSum = {{2{s1X_q[DW-1]}}, s1X_q}
           + {{2{hist_q[0][DW-1]}}, hist_q[0]}
           + {{2{hist_q[1][DW-1]}}, hist_q[1]}
           + {{2{hist_q[2][DW-1]}}, hist_q[2]};
    avgX_d = avgSum[DW+1:2];
    hist_d = hist_q;
    if (s1Valid_q) begin
      hist_d[0] = s1X_q;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      hist_q     <= '{default: '0};
      avgX_q     <= '0;
      avgGain_q  <= GAIN_RST;
      avgValid_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      avgX_q     <= avgX_d;
      avgGain_q  <= actGain_q;
      avgValid_q <= s1Valid_q;
    end
  end

  assign mulX     = avgX_q;
  assign mulG     = avgGain_q;
  assign mulValid = avgValid_q;
`else
  assign mulX     = s1X_q;
  assign mulG     = actGain_q;
  assign mulValid = s1Valid_q;
`endif

  // Full-width signed product always fits in DW+GW bits, so truncation is exact.
  assign mulXExt = {{GW{mulX[DW-1]}}, mulX};
  assign mulGExt = {{DW{mulG[GW-1]}}, mulG};
  assign prod_d  = mulXExt * mulGExt;
  assign shifted = prod_q >>> FRAC;

  always_comb begin
    s3Y_d    = shifted[DW-1:0];
    s3Clip_d = 1'b0;
    if (shifted > YMAX) begin
      s3Y_d    = YMAX[DW-1:0];
      s3Clip_d = 1'b1;
    end else if (shifted < YMIN) begin
      s3Y_d    = YMIN[DW-1:0];
      s3Clip_d = 1'b1;
    end
  end

  always_comb begin
    dataOut_d = dataOut_q;
    clip_d    = clip_q;
    clipCnt_d = clipCnt_q;
    if (s3Valid_q) begin
      dataOut_d = s3Y_q + DAC_OFFSET;
      clip_d    = s3Clip_q;
      if (s3Clip_q && (clipCnt_q != 16'hFFFF))
        clipCnt_d = clipCnt_q + 16'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      prod_q      <= '0;
      prodValid_q <= 1'b0;
      s3Y_q       <= '0;
      s3Clip_q    <= 1'b0;
      s3Valid_q   <= 1'b0;
      dataOut_q   <= DAC_OFFSET;
      clip_q      <= 1'b0;
      valid_q     <= 1'b0;
      clipCnt_q   <= 16'd0;
    end else begin
      prod_q      <= prod_d;
      prodValid_q <= mulValid;
      s3Y_q       <= s3Y_d;
      s3Clip_q    <= s3Clip_d;
      s3Valid_q   <= prodValid_q;
      dataOut_q   <= dataOut_d;
      clip_q      <= clip_d;
      valid_q     <= s3Valid_q;
      clipCnt_q   <= clipCnt_d;
    end
  end

  assign data_out   = dataOut_q;
  assign data_valid = valid_q;
  assign clip       = clip_q;
  assign clip_count = clipCnt_q;

endmodule

// File: tb/tb_gain_proc.sv
// Scoreboard bench for gain_proc: an arithmetic reference model queues expected outputs,
// a monitor pops them on data_valid. Honors MOVAVG4_EN like the design.
module tb_gain_proc;

`ifdef MOVAVG4_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [9:0]  data_in = '0;
  logic        gain_ld = 1'b0;
  logic [7:0]  gain_in = '0;
  logic [9:0]  data_out;
  logic        data_valid;
  logic        clip;
  logic [15:0] clip_count;

  gain_proc dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .sample_en  (sample_en),
    .data_in    (data_in),
    .gain_ld    (gain_ld),
    .gain_in    (gain_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .clip       (clip),
    .clip_count (clip_count)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int due;
    int dout;
    int clp;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   edgeCnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   pendG = 64;
  int   mCount = 0;
  int   holdData = 'h200;
  int   holdClip = 0;
  int   holdCount = 0;
  bit   monOn = 1'b0;
`ifdef MOVAVG4_EN
  int   hist[$];
`endif

  always @(posedge sysclk) edgeCnt++;

  function automatic int toSigned(input int v, input int w);
    int m;
    m = ((v % (1 << w)) + (1 << w)) % (1 << w);
    return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
  endfunction

  function automatic int floorDiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edgeCnt);
    end
  endtask

  // Drive one cycle of inputs and update the reference model for the edge that samples them.
  task automatic applyStimulus(input bit rst, input bit en, input int din, input bit ld, input int gin);
    int e, x, g, q, y, c;
    exp_t it;
    @(negedge sysclk);
    reset     = rst;
    sample_en = en;
    data_in   = din[9:0];
    gain_ld   = ld;
    gain_in   = gin[7:0];
    e = edgeCnt + 1;
    if (rst) begin
      while (sbq.size() > 0 && sbq[$].due >= e) void'(sbq.pop_back());
      pendG     = 64;
      mCount    = 0;
      holdData  = 'h200;
      holdClip  = 0;
      holdCount = 0;
`ifdef MOVAVG4_EN
      hist.delete();
`endif
    end else begin
      if (en) begin
        g = ld ? toSigned(gin, 8) : pendG;
        x = toSigned(din - 'h181, 10);
`ifdef MOVAVG4_EN
        begin
          int sum;
          hist.push_front(x);
          if (hist.size() > 4) void'(hist.pop_back());
          sum = 0;
          foreach (hist[i]) sum += hist[i];
          x = floorDiv(sum, 4);
        end
`endif
        q = floorDiv(x * g, 16);
        c = 0;
        y = q;
        if (q > 511) begin y = 511; c = 1; end
        if (q < -512) begin y = -512; c = 1; end
        if (c == 1 && mCount < 65535) mCount++;
        it.due  = e + LAT;
        it.dout = (y + 512 + 1024) % 1024;
        it.clp  = c;
        it.cnt  = mCount;
        sbq.push_back(it);
      end
      if (ld) pendG = toSigned(gin, 8);
    end
  endtask

  task automatic checkOutput();
    exp_t it;
    if (data_valid) begin
      if (sbq.size() == 0) begin
        cmp("spurious_valid", data_valid, 0);
      end else begin
        it = sbq.pop_front();
        cmp("latency_edge", edgeCnt, it.due);
        cmp("data_out", data_out, it.dout);
        cmp("clip", clip, it.clp);
        cmp("clip_count", clip_count, it.cnt);
        holdData  = it.dout;
        holdClip  = it.clp;
        holdCount = it.cnt;
      end
    end else begin
      if (sbq.size() > 0 && sbq[0].due <= edgeCnt) begin
        it = sbq.pop_front();
        cmp("missing_valid", data_valid, 1);
        holdData  = it.dout;
        holdClip  = it.clp;
        holdCount = it.cnt;
      end else begin
        cmp("hold_data_out", data_out, holdData);
        cmp("hold_clip", clip, holdClip);
        cmp("hold_clip_count", clip_count, holdCount);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge sysclk);
      #2;
      if (monOn) checkOutput();
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(1, 1, 'h3FF, 1, 'h7F);
    applyStimulus(1, 0, 0, 0, 0);
    monOn = 1'b1;
    idle(2);

    // Zero sample, then x=16 at default gain 4.0
    applyStimulus(0, 1, 'h181, 0, 0);
    applyStimulus(0, 1, 'h191, 0, 0);
    idle(LAT + 1);

    // Positive and negative saturation
    applyStimulus(0, 1, 'h281, 0, 0);
    applyStimulus(0, 1, 'h081, 0, 0);
    idle(LAT + 1);

    // Gain load concurrent with the second of three back-to-back samples
    applyStimulus(0, 1, 'h191, 0, 0);
    applyStimulus(0, 1, 'h191, 1, 'hF0);
    applyStimulus(0, 1, 'h191, 0, 0);
    idle(LAT + 1);
    applyStimulus(0, 0, 0, 1, 'h40);

    // Gapped samples, then reset right after the second sample
    applyStimulus(0, 1, 'h1A1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 'h171, 0, 0);
    idle(LAT + 1);
    applyStimulus(0, 1, 'h1A1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 'h171, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    idle(LAT + 2);

    // Unity gain, four equal samples x=40 (moving-average ramp when enabled)
    applyStimulus(0, 0, 0, 1, 'h10);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 'h1A9, 0, 0);
    idle(LAT + 1);

    // Randomized traffic with occasional gain loads and resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 9) < 7),
                    int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 255)));
    end
    idle(LAT + 3);

    cmp("drain_queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
